// File: rtl/climate_uart_reporter_if.sv
// Sensor-side and UART-side signals of the climate reporter, grouped for port binding.
interface climate_uart_reporter_if;
    logic [15:0] temp_in;
    logic [15:0] hum_in;
    logic        force_report;
    logic        tx;
    logic        vent;
    logic [3:0]  status;
    logic        busy;

    modport slave  (input temp_in, hum_in, force_report, output tx, vent, status, busy);
    modport master (output temp_in, hum_in, force_report, input tx, vent, status, busy);
endinterface

// File: rtl/climate_uart_reporter.sv
// Climate monitor: hysteretic vent control plus a periodic or forced 16-char ASCII
// status line sent over 8N1 UART with readings in decimal.
module climate_uart_reporter #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 9600,
    parameter int REPORT_CLKS = 50_000_000,
    parameter int GAP_CLKS    = 1000,
    parameter int TEMP_MAX    = 24,
    parameter int TEMP_MIN    = 14,
    parameter int HUM_MAX     = 80,
    parameter int HUM_MIN     = 60,
    parameter int HYST        = 2
) (
    input logic                    clk,
    input logic                    reset_n,
    climate_uart_reporter_if.slave bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_MAX      = (CLKS_PER_BIT > GAP_CLKS) ? CLKS_PER_BIT : GAP_CLKS;
    localparam int CW           = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int TW           = (REPORT_CLKS > 1) ? $clog2(REPORT_CLKS) : 1;
    // bit_idx 10 is the inter-byte gap; skipped entirely when there is no gap
    localparam logic [3:0] LAST_BIT = (GAP_CLKS > 0) ? 4'd10 : 4'd9;

    typedef enum logic [1:0] {IDLE, SNAP, CONV, SEND} state_t;

    state_t          state, state_nxt;
    logic            pend, pend_nxt, busy_c;
    logic [TW-1:0]   timer;
    logic            tick, trigger;
    logic            t_alta, t_baja, h_alta, h_baja;
    logic [3:0]      status_q;
    logic            vent_q;
    logic [21:0]     t_dd, h_dd;
    logic [1:0]      t_fl, h_fl;
    logic [3:0]      conv_cnt, bit_idx, byte_idx;
    logic [CW-1:0]   clk_cnt;
    logic            bit_end;
    logic [7:0]      cur_byte, ts_chr, hs_chr;
    logic [2:0]      data_idx;
    logic            tx_c;

    assign t_alta = bus.temp_in > 16'(TEMP_MAX);
    assign t_baja = bus.temp_in < 16'(TEMP_MIN);
    assign h_alta = bus.hum_in  > 16'(HUM_MAX);
    assign h_baja = bus.hum_in  < 16'(HUM_MIN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            status_q <= '0;
            vent_q   <= 1'b0;
        end else begin
            status_q <= {h_baja, h_alta, t_baja, t_alta};
            if (t_alta || h_alta)
                vent_q <= 1'b1;
            else if (bus.temp_in <= 16'(TEMP_MAX - HYST) && bus.hum_in <= 16'(HUM_MAX - HYST))
                vent_q <= 1'b0;
        end
    end

    assign tick    = (timer == TW'(REPORT_CLKS - 1));
    assign trigger = tick || bus.force_report;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) timer <= '0;
        else          timer <= tick ? '0 : timer + TW'(1);
    end

    // One add-3/shift step of double dabble on {bcd[11:0], bin[9:0]}
    function automatic logic [21:0] dd_step(input logic [21:0] x);
        logic [21:0] y;
        y = x;
        for (int i = 0; i < 3; i++)
            if (y[10+4*i +: 4] >= 4'd5) y[10+4*i +: 4] = y[10+4*i +: 4] + 4'd3;
        return {y[20:0], 1'b0};
    endfunction

    assign bit_end = (bit_idx == 4'd10) ? (clk_cnt == CW'(GAP_CLKS - 1))
                                        : (clk_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        busy_c    = 1'b1;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (trigger || pend) begin
                    state_nxt = SNAP;
                    pend_nxt  = 1'b0;
                end
            end
            SNAP: state_nxt = CONV;
            CONV: if (conv_cnt == 4'd9) state_nxt = SEND;
            SEND: if (bit_end && bit_idx == LAST_BIT && byte_idx == 4'd15) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A tick and a force in the same cycle, or repeated requests, collapse into one
        if (state != IDLE && trigger) pend_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_dd     <= '0;
            h_dd     <= '0;
            t_fl     <= '0;
            h_fl     <= '0;
            conv_cnt <= '0;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
        end else begin
            case (state)
                SNAP: begin
                    t_dd     <= {12'd0, (bus.temp_in > 16'd999) ? 10'd999 : bus.temp_in[9:0]};
                    h_dd     <= {12'd0, (bus.hum_in  > 16'd999) ? 10'd999 : bus.hum_in[9:0]};
                    t_fl     <= {t_alta, t_baja};
                    h_fl     <= {h_alta, h_baja};
                    conv_cnt <= '0;
                end
                CONV: begin
                    t_dd     <= dd_step(t_dd);
                    h_dd     <= dd_step(h_dd);
                    conv_cnt <= conv_cnt + 4'd1;
                    clk_cnt  <= '0;
                    bit_idx  <= '0;
                    byte_idx <= '0;
                end
                SEND: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
                            bit_idx  <= '0;
                            byte_idx <= byte_idx + 4'd1;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ts_chr = t_fl[1] ? "A" : (t_fl[0] ? "B" : "N");
    assign hs_chr = h_fl[1] ? "A" : (h_fl[0] ? "B" : "N");

    always_comb begin
        cur_byte = 8'h20;
        case (byte_idx)
            4'd0:  cur_byte = "T";
            4'd1:  cur_byte = "=";
            4'd2:  cur_byte = {4'h3, t_dd[21:18]};
            4'd3:  cur_byte = {4'h3, t_dd[17:14]};
            4'd4:  cur_byte = {4'h3, t_dd[13:10]};
            4'd6:  cur_byte = "H";
            4'd7:  cur_byte = "=";
            4'd8:  cur_byte = {4'h3, h_dd[21:18]};
            4'd9:  cur_byte = {4'h3, h_dd[17:14]};
            4'd10: cur_byte = {4'h3, h_dd[13:10]};
            4'd12: cur_byte = ts_chr;
            4'd13: cur_byte = hs_chr;
            4'd14: cur_byte = 8'h0D;
            4'd15: cur_byte = 8'h0A;
            default: cur_byte = 8'h20;
        endcase
    end

    assign data_idx = 3'(bit_idx - 4'd1);

    always_comb begin
        tx_c = 1'b1;
        if (state == SEND) begin
            if (bit_idx == 4'd0)
                tx_c = 1'b0;
            else if (bit_idx <= 4'd8)
                tx_c = cur_byte[data_idx];
        end
    end

    assign bus.tx     = tx_c;
    assign bus.vent   = vent_q;
    assign bus.status = status_q;
    assign bus.busy   = busy_c;
endmodule

// File: tb/tb_climate_uart_reporter.sv
// Directed bench for climate_uart_reporter: decodes the UART line cycle-by-cycle and
// checks content, bit/gap timing, vent hysteresis, status flags and trigger handling.
module tb_climate_uart_reporter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int failures = 0;

    climate_uart_reporter_if bus_if();

    climate_uart_reporter #(
        .CLK_FREQ(1000), .BAUD(100), .REPORT_CLKS(2000), .GAP_CLKS(5)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    task automatic do_reset(input logic [15:0] t, input logic [15:0] h);
        reset_n = 1'b0;
        bus_if.force_report = 1'b0;
        bus_if.temp_in = t;
        bus_if.hum_in = h;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic pulse_force();
        bus_if.force_report = 1'b1;
        @(negedge clk);
        bus_if.force_report = 1'b0;
    endtask

    task automatic wait_start(input int limit, output int n);
        n = 0;
        while (bus_if.tx !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Called on the first cycle of byte 0's start bit; returns after the last gap cycle.
    task automatic recv_line(output logic [127:0] line, output int bad);
        logic v;
        logic [9:0] fr;
        bad = 0;
        line = '0;
        fr = '0;
        for (int k = 0; k < 16; k++) begin
            if (bus_if.tx !== 1'b0) bad++;
            for (int bi = 0; bi < 10; bi++) begin
                v = bus_if.tx;
                for (int c = 0; c < 10; c++) begin
                    if (bus_if.tx !== v) bad++;
                    if (bus_if.busy !== 1'b1) bad++;
                    @(negedge clk);
                end
                fr[bi] = v;
            end
            if (fr[0] !== 1'b0 || fr[9] !== 1'b1) bad++;
            line[127-8*k -: 8] = fr[8:1];
            for (int g = 0; g < 5; g++) begin
                if (bus_if.tx !== 1'b1 || bus_if.busy !== 1'b1) bad++;
                @(negedge clk);
            end
        end
        if (bus_if.busy !== 1'b0) bad++;
    endtask

    task automatic check_line(input string name, input logic [127:0] got, input int bad,
                              input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s line: got %h expected %h", name, got, exp);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL %s framing: %0d bad cycles, expected 0", name, bad);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus_if.force_report = 1'b0;
        bus_if.temp_in = 16'd30;
        bus_if.hum_in = 16'd90;
        repeat (2) @(negedge clk);
        checks++; if (bus_if.tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", bus_if.tx); end
        checks++; if (bus_if.vent !== 1'b0) begin failures++; $display("FAIL reset_vent: got %b expected 0", bus_if.vent); end
        checks++; if (bus_if.status !== 4'b0000) begin failures++; $display("FAIL reset_status: got %b expected 0000", bus_if.status); end
        checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
    endtask

    task automatic test_tick_report();
        logic [127:0] l; int bad, n;
        do_reset(16'd20, 16'd70);
        repeat (2) @(negedge clk);
        checks++; if (bus_if.status !== 4'b0000) begin failures++; $display("FAIL tick_status: got %b expected 0000", bus_if.status); end
        checks++; if (bus_if.vent !== 1'b0) begin failures++; $display("FAIL tick_vent: got %b expected 0", bus_if.vent); end
        wait_start(2200, n);
        checks++;
        if (n < 1950 || n >= 2200) begin
            failures++; $display("FAIL tick_start: start after %0d cycles, expected about 2010", n);
        end else begin
            recv_line(l, bad);
            check_line("tick", l, bad, {"T=020 H=070 NN", 8'h0D, 8'h0A});
        end
    endtask

    task automatic test_hysteresis();
        logic [127:0] l; int bad, n;
        do_reset(16'd20, 16'd70);
        @(negedge clk);
        bus_if.temp_in = 16'd30; bus_if.hum_in = 16'd50;
        @(negedge clk);
        checks++; if (bus_if.status !== 4'b1001) begin failures++; $display("FAIL hyst_status: got %b expected 1001", bus_if.status); end
        checks++; if (bus_if.vent !== 1'b1) begin failures++; $display("FAIL hyst_vent_on: got %b expected 1", bus_if.vent); end
        pulse_force();
        wait_start(60, n);
        checks++;
        if (n > 42) begin
            failures++; $display("FAIL hyst_latency: %0d cycles, expected <= 42", n);
        end else begin
            recv_line(l, bad);
            check_line("hyst", l, bad, {"T=030 H=050 AB", 8'h0D, 8'h0A});
        end
        bus_if.temp_in = 16'd23;
        repeat (2) @(negedge clk);
        checks++; if (bus_if.vent !== 1'b1) begin failures++; $display("FAIL hyst_vent_hold: got %b expected 1", bus_if.vent); end
        bus_if.temp_in = 16'd22;
        @(negedge clk);
        checks++; if (bus_if.vent !== 1'b0) begin failures++; $display("FAIL hyst_vent_off: got %b expected 0", bus_if.vent); end
    endtask

    task automatic test_clamp();
        logic [127:0] l; int bad, n;
        do_reset(16'd1234, 16'd65535);
        repeat (2) @(negedge clk);
        pulse_force();
        wait_start(60, n);
        checks++;
        if (n > 42) begin
            failures++; $display("FAIL clamp_latency: %0d cycles, expected <= 42", n);
        end else begin
            recv_line(l, bad);
            check_line("clamp", l, bad, {"T=999 H=999 AA", 8'h0D, 8'h0A});
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] l; int bad, n, hi;
        do_reset(16'd20, 16'd70);
        repeat (350) @(negedge clk);
        pulse_force();
        wait_start(60, n);
        checks++;
        if (n > 42) begin
            failures++; $display("FAIL b2b_latency: %0d cycles, expected <= 42", n);
        end else begin
            fork
                recv_line(l, bad);
                begin
                    repeat (300) @(negedge clk);
                    for (int p = 0; p < 3; p++) begin
                        pulse_force();
                        repeat (20) @(negedge clk);
                    end
                end
            join
            check_line("b2b_first", l, bad, {"T=020 H=070 NN", 8'h0D, 8'h0A});
            wait_start(60, n);
            checks++;
            if (n > 42) begin
                failures++; $display("FAIL b2b_extra_start: %0d cycles, expected <= 42", n);
            end else begin
                recv_line(l, bad);
                check_line("b2b_extra", l, bad, {"T=020 H=070 NN", 8'h0D, 8'h0A});
                hi = 0;
                for (int c = 0; c < 200; c++) begin
                    if (bus_if.busy !== 1'b0) hi++;
                    @(negedge clk);
                end
                checks++;
                if (hi !== 0) begin
                    failures++; $display("FAIL b2b_no_third: busy high %0d cycles, expected 0", hi);
                end
            end
        end
    endtask

    task automatic test_snapshot();
        logic [127:0] l; int bad, n;
        do_reset(16'd20, 16'd70);
        repeat (2) @(negedge clk);
        pulse_force();
        wait_start(60, n);
        checks++;
        if (n > 42) begin
            failures++; $display("FAIL snap_latency: %0d cycles, expected <= 42", n);
        end else begin
            fork
                recv_line(l, bad);
                begin
                    repeat (400) @(negedge clk);
                    bus_if.temp_in = 16'd30;
                    @(negedge clk);
                    checks++; if (bus_if.status !== 4'b0001) begin failures++; $display("FAIL snap_status: got %b expected 0001", bus_if.status); end
                    checks++; if (bus_if.vent !== 1'b1) begin failures++; $display("FAIL snap_vent: got %b expected 1", bus_if.vent); end
                end
            join
            check_line("snap", l, bad, {"T=020 H=070 NN", 8'h0D, 8'h0A});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [127:0] l; int bad, n;
        do_reset(16'd25, 16'd81);
        repeat (2) @(negedge clk);
        pulse_force();
        wait_start(60, n);
        checks++;
        if (n > 42) begin
            failures++; $display("FAIL mid_latency: %0d cycles, expected <= 42", n);
        end else begin
            // 3 bytes of 105 cycles, then 3 cycles into byte 3's start bit
            repeat (318) @(negedge clk);
            checks++; if (bus_if.tx !== 1'b0) begin failures++; $display("FAIL mid_in_start: got %b expected 0", bus_if.tx); end
            reset_n = 1'b0;
            #1;
            checks++; if (bus_if.tx !== 1'b1) begin failures++; $display("FAIL mid_reset_tx: got %b expected 1", bus_if.tx); end
            checks++; if (bus_if.busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got %b expected 0", bus_if.busy); end
            @(negedge clk);
            reset_n = 1'b1;
            wait_start(2200, n);
            checks++;
            if (n >= 2200) begin
                failures++; $display("FAIL mid_tick_start: no start within %0d cycles, expected one", n);
            end else begin
                recv_line(l, bad);
                check_line("mid_after", l, bad, {"T=025 H=081 AA", 8'h0D, 8'h0A});
            end
        end
    endtask

    initial begin
        bus_if.force_report = 1'b0;
        bus_if.temp_in = '0;
        bus_if.hum_in = '0;
        test_reset();
        test_tick_report();
        test_hysteresis();
        test_clamp();
        test_back_to_back();
        test_snapshot();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
